// File: rtl/imem_arbiter.sv
// Two-port (fetch/debug) arbiter in front of a single-port registered instruction memory.
// Response one cycle after grant. Ready is combinational, and requests are never buffered.
// Priority is fixed, with debug starvation relief. Defining IMEM_ARB_RR_EN gives round-robin instead.
module imem_arbiter #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req_valid,
    input  logic [ADDR_W-1:0] f_req_addr,
    output logic              f_req_ready,
    input  logic              f_flush,
    output logic              f_rsp_valid,
    output logic [DATA_W-1:0] f_rsp_data,
    input  logic              d_req_valid,
    input  logic [ADDR_W-1:0] d_req_addr,
    output logic              d_req_ready,
    output logic              d_rsp_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_data_in
);

    logic              f_gnt, d_gnt;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              f_inflt_q, d_inflt_q;
    logic [DATA_W-1:0] f_hold_q, f_hold_d;
    logic [DATA_W-1:0] d_hold_q, d_hold_d;

`ifdef IMEM_ARB_RR_EN
    // rr_q set means fetch won last, so debug is favoured next; reset favours fetch.
    logic rr_q, rr_d;
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_q, starve_d;
`endif

    always_comb begin
        f_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (f_req_valid && d_req_valid) begin
`ifdef IMEM_ARB_RR_EN
                if (rr_q) d_gnt = 1'b1;
                else      f_gnt = 1'b1;
`else
                if (starve_q == LIMIT) d_gnt = 1'b1;
                else                   f_gnt = 1'b1;
`endif
            end else begin
                f_gnt = f_req_valid;
                d_gnt = d_req_valid;
            end
        end
    end

    assign f_req_ready = f_gnt;
    assign d_req_ready = d_gnt;

    always_comb begin
        addr_d = addr_q;
        if (f_gnt)      addr_d = f_req_addr;
        else if (d_gnt) addr_d = d_req_addr;
    end
    assign mem_address = addr_d;

    // A flush or reset in the response cycle kills the pulse and the hold update.
    assign f_rsp_valid = f_inflt_q && !f_flush && !reset;
    assign d_rsp_valid = d_inflt_q && !reset;

    assign f_hold_d   = f_rsp_valid ? mem_data_in : f_hold_q;
    assign d_hold_d   = d_rsp_valid ? mem_data_in : d_hold_q;
    assign f_rsp_data = f_hold_d;
    assign d_rsp_data = d_hold_d;

`ifdef IMEM_ARB_RR_EN
    always_comb begin
        rr_d = rr_q;
        if (f_gnt)      rr_d = 1'b1;
        else if (d_gnt) rr_d = 1'b0;
    end
`else
    // Counts fetch wins while debug waits; saturates at the limit.
    always_comb begin
        starve_d = starve_q;
        if (!d_req_valid || d_gnt)         starve_d = '0;
        else if (f_gnt && starve_q < LIMIT) starve_d = starve_q + 4'd1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            f_inflt_q <= 1'b0;
            d_inflt_q <= 1'b0;
            f_hold_q  <= '0;
            d_hold_q  <= '0;
`ifdef IMEM_ARB_RR_EN
            rr_q      <= 1'b0;
`else
            starve_q  <= '0;
`endif
        end else begin
            addr_q    <= addr_d;
            f_inflt_q <= f_gnt;
            d_inflt_q <= d_gnt;
            f_hold_q  <= f_hold_d;
            d_hold_q  <= d_hold_d;
`ifdef IMEM_ARB_RR_EN
            rr_q      <= rr_d;
`else
            starve_q  <= starve_d;
`endif
        end
    end

endmodule
